odometer_meas_ctrl: RTL and testbench
=====================================

# odometer_meas_ctrl

Measurement sequencer and edge counter for the odometer ring-oscillator block. It drives the block's power, enable, select and stress/reference controls through a fixed power-up, settle and count sequence. During a programmable window it counts rising edges of the returned oscillator output, then publishes the count with a one-cycle DONE pulse. It sits between the chip's register/scan interface and each `rosc_block_top_*` instance.

## Interface
Parameters:
- `CNT_W`, 16, width of edge counter and `COUNT`
- `WIN_W`, 16, width of `WIN_CYCLES`
- `SETTLE_CYC`, 8, cycles spent in each of POWER and ENABLE (≥1)

Ports:
- `CLK`  in  1  system clock
- `RST`  in  1  reset; asynchronous, active-high
- `MEAS_REQ`  in  1  start request, sampled in IDLE only
- `RO_SEL`  in  2  ring to measure: 0 INV, 1 NAND, 2 NOR, 3 reserved (treated as INV)
- `STRESS_SEL`  in  1  1 = measure stressed ring, 0 = reference ring
- `WIN_CYCLES`  in  WIN_W  count window length in CLK cycles
- `ROSC_OUT`  in  1  oscillator output from the rosc block; asynchronous to `CLK`
- `EN_POWER_ROSC`  out  1  ring power enable
- `EN_ROSC`  out  1  ring oscillation enable
- `MEAS_STRESS`  out  1  latched `STRESS_SEL`
- `SEL_INV`, `SEL_NAND`, `SEL_NOR`  out  1 each  one-hot ring select
- `BUSY`  out  1  measurement in progress
- `DONE`  out  1  one-cycle result-valid pulse
- `COUNT`  out  CNT_W  last measured edge count
- `OVF`  out  1  last measurement overflowed

## Operation
- `ROSC_OUT` passes through a 2-flop synchronizer. A rising-edge detector compares the synchronizer output with a third flop.
- States and transitions:
  - IDLE: on `MEAS_REQ`=1, latch `RO_SEL` and `STRESS_SEL`, then go to POWER.
  - POWER: `EN_POWER_ROSC`=1 and select one-hot driven. Remain for `SETTLE_CYC` cycles, then go to ENABLE.
  - ENABLE: additionally `EN_ROSC`=1, with the counter cleared. Remain for `SETTLE_CYC` cycles, then go to COUNT.
  - COUNT: count one per detected rising edge. Remain for `WIN_CYCLES` cycles, then go to DONE.
  - DONE: one cycle, then go to IDLE.
- DONE state actions: `COUNT` and `OVF` are loaded, `DONE`=1, and `EN_ROSC`, `EN_POWER_ROSC` and all selects drop to 0. `MEAS_STRESS` holds its value until the next request.
- `WIN_CYCLES`=0: COUNT state is skipped (ENABLE goes directly to DONE). Result is `COUNT`=0, `OVF`=0.
- Counter arithmetic is unsigned, CNT_W bits. The internal `OVF` flag sets on any increment from all-ones and stays set until the next ENABLE entry.
- `MEAS_REQ` outside IDLE is ignored; no queuing.
- `COUNT` and `OVF` hold their values between measurements.
- Input `ROSC_OUT` frequency must be < f_CLK/2 for exact counts.

## Timing
- Reset value of every output is 0. State returns to IDLE on `RST` at any time, including mid-measurement. The rings are powered down immediately on reset and no DONE pulse is issued.
- With the request sampled at edge k, and S = `SETTLE_CYC`, W = `WIN_CYCLES`:
  - POWER occupies cycles k+1 … k+S.
  - ENABLE occupies cycles k+S+1 … k+2S.
  - COUNT occupies cycles k+2S+1 … k+2S+W.
  - `DONE`=1 in cycle k+2S+W+1.
- `BUSY`=1 in cycles k+1 … k+2S+W. `BUSY` is 0 in the DONE cycle, so a new request is accepted one cycle after DONE.
- Only edges whose detector output is high during COUNT cycles are counted. Synchronizer latency is 2 cycles and is not compensated.
- `COUNT` and `OVF` update on the same edge that raises `DONE`.

## Configuration
- `ODOMETER_CNT_SAT_EN`:
  - Defined: the counter saturates at all-ones and `OVF` is still set.
  - Undefined: the counter wraps to 0 and `OVF` is set.

## Test plan
- **Basic count:** S=8, W=100, `RO_SEL`=0, `ROSC_OUT` a CLK-aligned square wave with period 4 CLK. Expect `SEL_INV`=1 for the duration, `COUNT`=25, `OVF`=0, and `DONE` exactly 117 cycles after the request edge.
- **Select and stress:** `RO_SEL`=2, `STRESS_SEL`=1. Expect `SEL_NOR`=1 and `MEAS_STRESS`=1 throughout; `SEL_INV`=`SEL_NAND`=0; selects return to 0 after DONE.
- **Overflow:** CNT_W=4, W=80, `ROSC_OUT` period 4.
  - Without the macro: `COUNT`=20 mod 16 = 4, `OVF`=1.
  - With `ODOMETER_CNT_SAT_EN`: `COUNT`=15, `OVF`=1.
- **Zero window:** W=0. Expect `DONE` at k+2S+1, `COUNT`=0, `OVF`=0.
- **Reset mid-COUNT:** assert `RST` mid-COUNT. Expect all outputs 0 immediately and no `DONE`. A subsequent request completes normally.
- **Busy request:** pulse `MEAS_REQ` during ENABLE. Expect it to be ignored: a single `DONE` occurs and `BUSY` stays low afterwards.

Source files
------------

// File: rtl/odometer_meas_ctrl.sv
// Ring-oscillator measurement sequencer: power -> enable -> count window -> done, with edge counter.
// Optional ODOMETER_CNT_SAT_EN: counter saturates at all-ones instead of wrapping (OVF set either way).
module odometer_meas_ctrl #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MEAS_REQ,
  input  logic [1:0]       RO_SEL,
  input  logic             STRESS_SEL,
  input  logic [WIN_W-1:0] WIN_CYCLES,
  input  logic             ROSC_OUT,
  output logic             EN_POWER_ROSC,
  output logic             EN_ROSC,
  output logic             MEAS_STRESS,
  output logic             SEL_INV,
  output logic             SEL_NAND,
  output logic             SEL_NOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_POWER, S_ENABLE, S_COUNT, S_DONE} state_t;

  state_t             state;
  logic [TMR_W-1:0]   tmr;
  logic [WIN_W-1:0]   win_q;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               ovf, ovf_nxt;
  logic [2:0]         rosc_sync;
  logic               rosc_rise;
  logic               finish;

  // [1:0] is the synchronizer, [2] the delayed copy for edge detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rosc_sync <= '0;
    else     rosc_sync <= {rosc_sync[1:0], ROSC_OUT};
  end

  assign rosc_rise = rosc_sync[1] & ~rosc_sync[2];

  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (rosc_rise) begin
      if (&cnt) begin
        ovf_nxt = 1'b1;
`ifdef ODOMETER_CNT_SAT_EN
        cnt_nxt = cnt;
`else
        cnt_nxt = '0;
`endif
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // Last cycle of the measurement: end of COUNT, or end of ENABLE with an empty window
  assign finish = (tmr == '0) &&
                  ((state == S_COUNT) || (state == S_ENABLE && win_q == '0));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= S_IDLE;
      tmr           <= '0;
      win_q         <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      EN_POWER_ROSC <= 1'b0;
      EN_ROSC       <= 1'b0;
      MEAS_STRESS   <= 1'b0;
      SEL_INV       <= 1'b0;
      SEL_NAND      <= 1'b0;
      SEL_NOR       <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      COUNT         <= '0;
      OVF           <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: if (MEAS_REQ) begin
          state         <= S_POWER;
          tmr           <= SETTLE_LAST;
          win_q         <= WIN_CYCLES;
          MEAS_STRESS   <= STRESS_SEL;
          EN_POWER_ROSC <= 1'b1;
          BUSY          <= 1'b1;
          SEL_NAND      <= (RO_SEL == 2'd1);
          SEL_NOR       <= (RO_SEL == 2'd2);
          SEL_INV       <= (RO_SEL == 2'd0) || (RO_SEL == 2'd3);
        end
        S_POWER: begin
          if (tmr == '0) begin
            state   <= S_ENABLE;
            tmr     <= SETTLE_LAST;
            EN_ROSC <= 1'b1;
            cnt     <= '0;
            ovf     <= 1'b0;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_ENABLE: begin
          if (tmr == '0) begin
            state <= S_COUNT;
            tmr   <= TMR_W'(win_q - WIN_W'(1));
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_COUNT: begin
          cnt <= cnt_nxt;
          ovf <= ovf_nxt;
          tmr <= tmr - TMR_W'(1);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Overrides the case above on the final cycle
      if (finish) begin
        state         <= S_DONE;
        COUNT         <= (state == S_COUNT) ? cnt_nxt : '0;
        OVF           <= (state == S_COUNT) ? ovf_nxt : 1'b0;
        DONE          <= 1'b1;
        BUSY          <= 1'b0;
        EN_POWER_ROSC <= 1'b0;
        EN_ROSC       <= 1'b0;
        SEL_INV       <= 1'b0;
        SEL_NAND      <= 1'b0;
        SEL_NOR       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_odometer_meas_ctrl.sv
// Directed bench for odometer_meas_ctrl: a 16-bit and a 4-bit counter instance share all inputs.
module tb_odometer_meas_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        meas_req;
  logic [1:0]  ro_sel;
  logic        stress_sel;
  logic [15:0] win_cycles;
  logic        rosc_out = 1'b0;

  logic        en_power, en_rosc, ms, inv, nand_s, nor_s, busy, done, ovf;
  logic [15:0] count;
  logic        en_power_s, en_rosc_s, ms_s, inv_s, nand_ss, nor_ss, busy_s, done_s, ovf_s;
  logic [3:0]  count_s;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Square wave with period 4 CLK, changing on the falling edge
  initial forever begin
    repeat (2) @(negedge clk);
    rosc_out = ~rosc_out;
  end

  odometer_meas_ctrl #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(8)) dut (
    .CLK(clk), .RST(rst), .MEAS_REQ(meas_req), .RO_SEL(ro_sel), .STRESS_SEL(stress_sel),
    .WIN_CYCLES(win_cycles), .ROSC_OUT(rosc_out), .EN_POWER_ROSC(en_power), .EN_ROSC(en_rosc),
    .MEAS_STRESS(ms), .SEL_INV(inv), .SEL_NAND(nand_s), .SEL_NOR(nor_s), .BUSY(busy),
    .DONE(done), .COUNT(count), .OVF(ovf));

  odometer_meas_ctrl #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(8)) dut_s (
    .CLK(clk), .RST(rst), .MEAS_REQ(meas_req), .RO_SEL(ro_sel), .STRESS_SEL(stress_sel),
    .WIN_CYCLES(win_cycles), .ROSC_OUT(rosc_out), .EN_POWER_ROSC(en_power_s), .EN_ROSC(en_rosc_s),
    .MEAS_STRESS(ms_s), .SEL_INV(inv_s), .SEL_NAND(nand_ss), .SEL_NOR(nor_ss), .BUSY(busy_s),
    .DONE(done_s), .COUNT(count_s), .OVF(ovf_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {7'd0, en_power, en_rosc, ms, inv, nand_s, nor_s, busy, done, ovf, count}
         | {16'd0, en_power_s, en_rosc_s, ms_s, inv_s, nand_ss, nor_ss, busy_s, done_s, ovf_s, 3'd0, count_s};
  endfunction

  // Issue one request and follow it to DONE; lat is the cycle index of DONE relative to the request edge.
  task automatic do_meas(input logic [1:0] sel, input logic st, input logic [15:0] win, input int pulse_at,
                         output int lat, output int sel_err, output logic [1:0] pe_pow, output logic [1:0] pe_en);
    logic [2:0] exp_sel;
    exp_sel = (sel == 2'd1) ? 3'b010 : (sel == 2'd2) ? 3'b100 : 3'b001;
    @(negedge clk);
    ro_sel = sel; stress_sel = st; win_cycles = win; meas_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    meas_req = 1'b0;
    lat = 1; sel_err = 0; pe_pow = 2'b00; pe_en = 2'b00;
    while (!done && lat < 400) begin
      if (lat == 1) pe_pow = {en_power, en_rosc};
      if (lat == 9) pe_en  = {en_power, en_rosc};
      if (!busy || {nor_s, nand_s, inv} != exp_sel || ms != st) sel_err++;
      meas_req = (lat == pulse_at);
      @(negedge clk);
      lat++;
    end
    meas_req = 1'b0;
  endtask

  int lat, serr, ndone, nbusy;
  logic [1:0] pp, pe;

  initial begin
    rst = 1'b1; meas_req = 1'b0; ro_sel = 2'd0; stress_sel = 1'b0; win_cycles = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", all_out(), 32'd0);

    // Basic count: 100-cycle window over a period-4 wave
    do_meas(2'd0, 1'b0, 16'd100, 0, lat, serr, pp, pe);
    chk("basic_latency", lat, 117);
    chk("basic_sel_hold", serr, 0);
    chk("basic_power_phase", pp, 2'b10);
    chk("basic_enable_phase", pe, 2'b11);
    chk("basic_count", count, 25);
    chk("basic_ovf", ovf, 0);
    chk("basic_done_cycle_ctl", {busy, en_power, en_rosc, inv, nand_s, nor_s}, 0);
    @(negedge clk);
    chk("basic_done_single", done, 0);

    // NOR ring, stressed
    do_meas(2'd2, 1'b1, 16'd20, 0, lat, serr, pp, pe);
    chk("nor_latency", lat, 37);
    chk("nor_sel_hold", serr, 0);
    chk("nor_count", count, 5);
    @(negedge clk);
    chk("nor_after_sel", {inv, nand_s, nor_s}, 0);
    chk("nor_stress_held", ms, 1);

    do_meas(2'd1, 1'b0, 16'd12, 0, lat, serr, pp, pe);
    chk("nand_sel_hold", serr, 0);
    chk("nand_count", count, 3);
    do_meas(2'd3, 1'b0, 16'd12, 0, lat, serr, pp, pe);
    chk("rsvd_sel_inv", serr, 0);

    // Overflow on the 4-bit instance: 20 edges
    do_meas(2'd0, 1'b0, 16'd80, 0, lat, serr, pp, pe);
    chk("ovf_big_count", count, 20);
    chk("ovf_big_flag", ovf, 0);
`ifdef ODOMETER_CNT_SAT_EN
    chk("ovf_small_count", count_s, 15);
`else
    chk("ovf_small_count", count_s, 4);
`endif
    chk("ovf_small_flag", ovf_s, 1);
    chk("ovf_small_done", done_s, 1);

    // Zero window
    do_meas(2'd0, 1'b0, 16'd0, 0, lat, serr, pp, pe);
    chk("zero_latency", lat, 17);
    chk("zero_count", count, 0);
    chk("zero_ovf", ovf, 0);
    chk("zero_small_ovf_clr", {ovf_s, count_s}, 0);

    // Reset in the middle of COUNT
    @(negedge clk);
    win_cycles = 16'd100; stress_sel = 1'b1; meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
    repeat (40) @(negedge clk);
    chk("midreset_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("midreset_outputs", all_out(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (150) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("midreset_no_done", ndone, 0);
    do_meas(2'd0, 1'b0, 16'd8, 0, lat, serr, pp, pe);
    chk("midreset_recover_lat", lat, 25);
    chk("midreset_recover_count", count, 2);

    // Request pulsed during ENABLE is ignored
    do_meas(2'd0, 1'b0, 16'd12, 12, lat, serr, pp, pe);
    chk("busyreq_latency", lat, 29);
    chk("busyreq_count", count, 3);
    ndone = 0; nbusy = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("busyreq_no_extra_done", ndone, 0);
    chk("busyreq_busy_low", nbusy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
